// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Instruction-fetch front end and IF/ID pipeline register for the 5-stage
//   MIPS core. Owns the PC and the instruction-memory request handshake.
//   A one-entry skid buffer catches a fetch that returns while decode is
//   stalled. The IF/ID fields that the hazard unit reads are decoded here.
//
//   Optional feature: define DELAY_SLOT_EN to get the MIPS branch delay slot.
//   On a redirect, the instruction that was returned that same cycle (or the
//   one waiting in the skid buffer) is kept. Without the macro, a redirect
//   squashes that instruction.
//
// Ports
//   clk, rst        core clock; synchronous active-high reset
//   d_stall         decode stall request from the hazard unit
//   d_redirect      decode resolved a taken branch/jump this cycle
//   d_redirect_pc   redirect target
//   imem_req        fetch request valid
//   imem_addr       fetch address (current pc)
//   imem_ready      imem_rdata valid for the outstanding request
//   imem_rdata      fetched instruction
//   fd_valid        IF/ID holds a real instruction
//   fd_instr        IF/ID instruction
//   fd_pc4          PC+4 of the IF/ID instruction (JAL link value)
//   fd_opcode, fd_funct, fd_rs, fd_rt   IF/ID instruction fields
//   d_isSLL_SRL     IF/ID instruction is SLL or SRL
//   dx_bubble       force a NOP into ID/EX this cycle
//   stall_count     saturating count of bubble cycles
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | first cycle out of reset, no request issued
// S_FETCH | request outstanding at pc, waiting for imem_ready
// S_HELD  | skid buffer holds the instruction at pc, no request issued

module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_stall,
    input  logic             d_redirect,
    input  logic [31:0]      d_redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             fd_valid,
    output logic [31:0]      fd_instr,
    output logic [31:0]      fd_pc4,
    output logic [5:0]       fd_opcode,
    output logic [5:0]       fd_funct,
    output logic [4:0]       fd_rs,
    output logic [4:0]       fd_rt,
    output logic             d_isSLL_SRL,
    output logic             dx_bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_buf;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Request and bubble are forced low while rst is high, even in the first
    // reset cycle before the registers have been cleared.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;
    assign dx_bubble = d_stall && fd_valid && !rst;

    assign fd_opcode   = fd_instr[31:26];
    assign fd_funct    = fd_instr[5:0];
    assign fd_rs       = fd_instr[25:21];
    assign fd_rt       = fd_instr[20:16];
    assign d_isSLL_SRL = (fd_opcode == 6'b000000) &&
                         ((fd_funct == 6'b000000) || (fd_funct == 6'b000010));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT;
            pc          <= RESET_PC;
            skid_buf    <= NOP_INSTR;
            fd_instr    <= NOP_INSTR;
            fd_pc4      <= 32'd0;
            fd_valid    <= 1'b0;
            stall_count <= '0;
        end else begin
            if (dx_bubble && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            case (state)
                S_INIT: begin
                    state <= S_FETCH;
                end

                S_FETCH: begin
                    if (d_stall) begin
                        // IF/ID and pc hold; a returning fetch parks in the buffer.
                        if (imem_ready) begin
                            skid_buf <= imem_rdata;
                            state    <= S_HELD;
                        end
                    end else if (d_redirect) begin
                        pc <= d_redirect_pc;
`ifdef DELAY_SLOT_EN
                        if (imem_ready) begin
                            fd_instr <= imem_rdata;
                            fd_pc4   <= pc_plus4;
                            fd_valid <= 1'b1;
                        end else begin
                            fd_instr <= NOP_INSTR;
                            fd_valid <= 1'b0;
                        end
`else
                        fd_instr <= NOP_INSTR;
                        fd_valid <= 1'b0;
`endif
                    end else if (imem_ready) begin
                        fd_instr <= imem_rdata;
                        fd_pc4   <= pc_plus4;
                        fd_valid <= 1'b1;
                        pc       <= pc_plus4;
                    end else begin
                        fd_instr <= NOP_INSTR;
                        fd_valid <= 1'b0;
                    end
                end

                S_HELD: begin
                    if (!d_stall) begin
                        state <= S_FETCH;
                        if (d_redirect) begin
                            pc <= d_redirect_pc;
`ifdef DELAY_SLOT_EN
                            fd_instr <= skid_buf;
                            fd_pc4   <= pc_plus4;
                            fd_valid <= 1'b1;
`else
                            fd_instr <= NOP_INSTR;
                            fd_valid <= 1'b0;
`endif
                        end else begin
                            fd_instr <= skid_buf;
                            fd_pc4   <= pc_plus4;
                            fd_valid <= 1'b1;
                            pc       <= pc_plus4;
                        end
                    end
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule
